// File: rtl/operand_stage_if.sv
// operand_stage_if: instruction-in, ALU-bundle-out and writeback bus of the
// operand stage.
// Handshake: a transfer happens on the rising edge where valid && ready. A
// producer holds valid and its payload stable until that edge. ready may
// depend combinationally on valid and on the payload.
interface operand_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              alu_valid;
  logic              alu_ready;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_left;
  logic [DATA_W-1:0] alu_right;
  logic [4:0]        alu_rd;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              illegal;

  // Stage side.
  modport master (
    input  in_valid, in_instr, alu_ready, wb_valid, wb_rd, wb_data,
    output in_ready, alu_valid, alu_opcode, alu_left, alu_right, alu_rd, illegal
  );

  // Environment side: instruction source, ALU and writeback.
  modport slave (
    output in_valid, in_instr, alu_ready, wb_valid, wb_rd, wb_data,
    input  in_ready, alu_valid, alu_opcode, alu_left, alu_right, alu_rd, illegal
  );
endinterface

// File: rtl/operand_stage.sv
// operand_stage: RV32I decode and operand fetch for ADD/SUB/AND/ADDI/ANDI.
// The stage holds a 32x32 register file, a per-register pending scoreboard
// and a registered ALU bundle.
// Optional feature: define OPERAND_BYPASS_EN to forward same-cycle writeback
// data into the operands and to clear the matching hazard in that cycle.
module operand_stage #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_stage_if.master bus
);

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic [DATA_W-1:0] rf [32];
  logic [31:0]       pending;
  logic [31:0]       pending_nxt;

  logic              alu_valid_q;
  logic [2:0]        alu_opcode_q;
  logic [DATA_W-1:0] alu_left_q;
  logic [DATA_W-1:0] alu_right_q;
  logic [4:0]        alu_rd_q;
  logic              illegal_q;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, legal;
  logic [2:0] dec_op;
  logic       pend_rs1, pend_rs2, pend_rd, hazard;
  logic       accept;
  logic [DATA_W-1:0] rs1_val, rs2_val, imm;

  assign opc = bus.in_instr[6:0];
  assign rd  = bus.in_instr[11:7];
  assign f3  = bus.in_instr[14:12];
  assign rs1 = bus.in_instr[19:15];
  assign rs2 = bus.in_instr[24:20];
  assign f7  = bus.in_instr[31:25];
  assign imm = {{(DATA_W-12){bus.in_instr[31]}}, bus.in_instr[31:20]};

  // Decode the supported encodings into an ALU opcode and a legality flag.
  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    dec_op = ALU_OP_ADD;
    if (opc == OPC_R) begin
      if (f3 == 3'b000 && f7 == 7'b0000000) begin
        is_r   = 1'b1;
        dec_op = ALU_OP_ADD;
      end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
        is_r   = 1'b1;
        dec_op = ALU_OP_SUB;
      end else if (f3 == 3'b111 && f7 == 7'b0000000) begin
        is_r   = 1'b1;
        dec_op = ALU_OP_AND;
      end
    end else if (opc == OPC_I) begin
      if (f3 == 3'b000) begin
        is_i   = 1'b1;
        dec_op = ALU_OP_ADD;
      end else if (f3 == 3'b111) begin
        is_i   = 1'b1;
        dec_op = ALU_OP_AND;
      end
    end
    legal = is_r | is_i;
  end

  // Hazard check against the scoreboard; x0 is never pending, and illegal
  // words bypass the check entirely.
  always_comb begin
    pend_rs1 = pending[rs1];
    pend_rs2 = pending[rs2];
    pend_rd  = pending[rd];
`ifdef OPERAND_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd == rs1) pend_rs1 = 1'b0;
    if (bus.wb_valid && bus.wb_rd == rs2) pend_rs2 = 1'b0;
    if (bus.wb_valid && bus.wb_rd == rd)  pend_rd  = 1'b0;
`endif
    hazard = bus.in_valid && legal && (pend_rs1 || (is_r && pend_rs2) || pend_rd);
  end

  assign bus.in_ready = (!alu_valid_q || bus.alu_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  // Register file read, with optional same-cycle writeback forwarding.
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
`ifdef OPERAND_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd == rs1 && rs1 != 5'd0) rs1_val = bus.wb_data;
    if (bus.wb_valid && bus.wb_rd == rs2 && rs2 != 5'd0) rs2_val = bus.wb_data;
`endif
  end

  // Scoreboard next state: writeback clears, a same-cycle issue to that rd wins.
  always_comb begin
    pending_nxt = pending;
    if (bus.wb_valid) pending_nxt[bus.wb_rd] = 1'b0;
    if (accept && legal && rd != 5'd0) pending_nxt[rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Register file: writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_valid && bus.wb_rd != 5'd0) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ALU bundle: load on legal accept, hold under backpressure, drop after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q  <= 1'b0;
      alu_opcode_q <= 3'd0;
      alu_left_q   <= '0;
      alu_right_q  <= '0;
      alu_rd_q     <= 5'd0;
    end else if (accept && legal) begin
      alu_valid_q  <= 1'b1;
      alu_opcode_q <= dec_op;
      alu_left_q   <= rs1_val;
      alu_right_q  <= is_r ? rs2_val : imm;
      alu_rd_q     <= rd;
    end else if (bus.alu_ready) begin
      alu_valid_q  <= 1'b0;
    end
  end

  // One-cycle pulse for each consumed unsupported word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= accept && !legal;
  end

  assign bus.alu_valid  = alu_valid_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_left   = alu_left_q;
  assign bus.alu_right  = alu_right_q;
  assign bus.alu_rd     = alu_rd_q;
  assign bus.illegal    = illegal_q;

endmodule
